line_refill_unit: RTL and testbench

Refill controller between the instruction cache and the 32-bit main-memory port. When the cache reports a miss, it fetches the whole line as NrWordsPerLine sequential word reads over a req/gnt/rvalid bus. It assembles the words into one LineSize-bit line and returns it to the cache with a single-cycle valid pulse. It is the stage directly downstream of the cache's refill interface.

---
 rtl/line_refill_unit.sv | 108 ++++++++++
 tb/tb_line_refill_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_refill_unit.sv
// Refill controller: fetches one cache line as NrWordsPerLine pipelined word reads and returns it with a one-cycle valid.
// Requests issue from the cycle after the miss; the line pulse follows the last rvalid by one cycle.
module line_refill_unit #(
    parameter  int unsigned NrWordsPerLine = 4,
    localparam int unsigned LineSize       = 32 * NrWordsPerLine,
    localparam int unsigned ByteOffsetBits = 2 + $clog2(NrWordsPerLine)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cache_read_en_i,
    input  logic [31:0]         cache_addr_i,
    output logic                cache_read_valid_o,
    output logic [LineSize-1:0] cache_read_data_o,
    output logic                mem_req_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic                err_o
);
    localparam int unsigned IdxW = $clog2(NrWordsPerLine);
    localparam int unsigned CntW = IdxW + 1;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

    state_e                     state_q, state_d;
    logic [31-ByteOffsetBits:0] base_q, base_d;
    logic [CntW-1:0]            issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]            recv_cnt_q, recv_cnt_d;
    logic [LineSize-1:0]        line_q, line_d;
    logic                       err_q, err_d;

    // The cache hands over a line-aligned address; the offset bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cache_addr_i[ByteOffsetBits-1:0];

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        issue_cnt_d        = issue_cnt_q;
        recv_cnt_d         = recv_cnt_q;
        line_d             = line_q;
        err_d              = err_q;
        mem_req_o          = 1'b0;
        mem_addr_o         = 32'h0;
        cache_read_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (cache_read_en_i) begin
                    base_d      = cache_addr_i[31:ByteOffsetBits];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                mem_req_o  = (issue_cnt_q < CntW'(NrWordsPerLine));
                mem_addr_o = {base_q, issue_cnt_q[IdxW-1:0], 2'b00};
                if (mem_req_o && mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + CntW'(1);
                end
                // A response with nothing outstanding is a bus protocol error, not data.
                if (mem_rvalid_i) begin
                    if (recv_cnt_q == issue_cnt_q) begin
                        err_d = 1'b1;
                    end else begin
                        line_d[32*recv_cnt_q[IdxW-1:0] +: 32] = mem_rdata_i;
                        recv_cnt_d = recv_cnt_q + CntW'(1);
                        if (recv_cnt_q == CntW'(NrWordsPerLine - 1)) begin
                            state_d = RESP;
                        end
                    end
                end
            end
            RESP: begin
                cache_read_valid_o = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mem_rvalid_i && (state_q != FILL)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            line_q      <= line_d;
            err_q       <= err_d;
        end
    end

    assign cache_read_data_o = line_q;
    assign err_o             = err_q;
endmodule

// File: tb/tb_line_refill_unit.sv
// Directed bench for line_refill_unit with a behavioural in-order memory responder.
module tb_line_refill_unit;
    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         cache_read_en_i;
    logic [31:0]  cache_addr_i;
    logic         cache_read_valid_o;
    logic [127:0] cache_read_data_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic         err_o;

    line_refill_unit #(.NrWordsPerLine(4)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cache_read_en_i    (cache_read_en_i),
        .cache_addr_i       (cache_addr_i),
        .cache_read_valid_o (cache_read_valid_o),
        .cache_read_data_o  (cache_read_data_o),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           lat     = 1;
    logic [31:0]  data_base = 32'h0;
    logic         spur    = 1'b0;
    int           stall_beat = 0;
    int           stall_left = 0;
    logic [31:0]  stall_addr_exp = 32'h0;
    logic [31:0]  addr_log[16];
    int           n_addr, n_valid, n_rv, n_stall, stall_bad, first_req_cyc, valid_cyc, c0;
    logic [127:0] line_cap;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // One clock: drive memory-side inputs just after the edge, observe mid-cycle.
    task automatic step();
        pend_t p;
        @(posedge clk_i);
        #1;
        cyc++;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        if (spur) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            spur         = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p            = pend.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = data_base + {30'b0, p.addr[3:2]};
        end
        mem_gnt_i = 1'b1;
        if (mem_req_o && n_addr == stall_beat && stall_left > 0) begin
            mem_gnt_i = 1'b0;
            stall_left--;
        end
        #3;
        if (mem_req_o && mem_gnt_i) begin
            if (n_addr == 0) first_req_cyc = cyc;
            if (n_addr < 16) addr_log[n_addr] = mem_addr_o;
            n_addr++;
            pend.push_back('{addr: mem_addr_o, due: cyc + lat});
        end
        if (mem_req_o && !mem_gnt_i) begin
            n_stall++;
            if (mem_addr_o != stall_addr_exp) stall_bad++;
        end
        if (mem_rvalid_i) n_rv++;
        if (cache_read_valid_o) begin
            n_valid++;
            valid_cyc       = cyc;
            line_cap        = cache_read_data_o;
            cache_read_en_i = 1'b0;
        end
    endtask

    task automatic start_fill(input logic [31:0] a, input logic [31:0] db);
        n_addr = 0; n_valid = 0; n_rv = 0; n_stall = 0; stall_bad = 0;
        first_req_cyc = -1; valid_cyc = -1;
        data_base       = db;
        cache_addr_i    = a;
        cache_read_en_i = 1'b1;
        c0              = cyc;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && n_valid == 0; i++) step();
        chk({tag, "_done"}, 128'(n_valid != 0), 128'd1);
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] base);
        chk({tag, "_nbeats"}, 128'(n_addr), 128'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_addr%0d", tag, i), 128'(addr_log[i]), 128'(base + 32'(4 * i)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; cache_read_en_i = 1'b0; cache_addr_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        n_addr = 0; n_valid = 0; n_rv = 0; n_stall = 0; stall_bad = 0;
        first_req_cyc = -1; valid_cyc = -1; c0 = 0; line_cap = '0;
        for (int i = 0; i < 16; i++) addr_log[i] = 32'h0;
        #3;
        chk("rst_valid", 128'(cache_read_valid_o), 128'd0);
        chk("rst_req",   128'(mem_req_o), 128'd0);
        chk("rst_addr",  128'(mem_addr_o), 128'd0);
        chk("rst_data",  cache_read_data_o, 128'd0);
        chk("rst_err",   128'(err_o), 128'd0);
        step(); step();
        rstn_i = 1'b1;
        step();

        // Back-to-back fill: gnt every cycle, rvalid one cycle later.
        lat = 1;
        start_fill(32'h0000_1230, 32'hA0);
        wait_valid("b2b", 20);
        check_addrs("b2b", 32'h0000_1230);
        chk("b2b_first_req", 128'(first_req_cyc), 128'(c0 + 1));
        chk("b2b_valid_cyc", 128'(valid_cyc), 128'(c0 + 6));
        chk("b2b_line", line_cap, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        step(); step(); step();
        chk("b2b_one_pulse", 128'(n_valid), 128'd1);
        chk("b2b_req_idle", 128'(mem_req_o), 128'd0);
        chk("b2b_data_hold", cache_read_data_o, exp_line(32'hA0));

        // Second beat stalled three cycles, five-cycle read latency.
        lat = 5; stall_beat = 1; stall_left = 3; stall_addr_exp = 32'h0000_1234;
        start_fill(32'h0000_1230, 32'h1000);
        wait_valid("stall", 40);
        check_addrs("stall", 32'h0000_1230);
        chk("stall_cycles", 128'(n_stall), 128'd3);
        chk("stall_addr_held", 128'(stall_bad), 128'd0);
        chk("stall_valid_cyc", 128'(valid_cyc), 128'(c0 + 13));
        chk("stall_line", line_cap, exp_line(32'h1000));
        step(); step();
        chk("stall_one_pulse", 128'(n_valid), 128'd1);

        // Address swap and read_en drop during FILL must not disturb the fill.
        lat = 2;
        start_fill(32'h0000_1230, 32'hB0);
        step(); step();
        cache_addr_i = 32'hFFFF_FFF0;
        step();
        cache_read_en_i = 1'b0;
        wait_valid("achg", 30);
        check_addrs("achg", 32'h0000_1230);
        chk("achg_line", line_cap, exp_line(32'hB0));

        // Asynchronous reset after two responses of a fill.
        lat = 1;
        start_fill(32'h0000_1230, 32'hE0);
        for (int i = 0; i < 20 && n_rv < 2; i++) step();
        chk("rstmid_two_rv", 128'(n_rv), 128'd2);
        rstn_i = 1'b0;
        cache_read_en_i = 1'b0;
        pend.delete();
        #1;
        chk("rstmid_valid", 128'(cache_read_valid_o), 128'd0);
        chk("rstmid_req",   128'(mem_req_o), 128'd0);
        chk("rstmid_addr",  128'(mem_addr_o), 128'd0);
        chk("rstmid_data",  cache_read_data_o, 128'd0);
        step(); step();
        rstn_i = 1'b1;
        step();
        chk("rstmid_err", 128'(err_o), 128'd0);
        start_fill(32'h0000_0040, 32'hC0);
        wait_valid("post_rst", 20);
        check_addrs("post_rst", 32'h0000_0040);
        chk("post_rst_line", line_cap, exp_line(32'hC0));
        step(); step();

        // Spurious rvalid while idle.
        spur = 1'b1;
        step(); step();
        chk("spur_err", 128'(err_o), 128'd1);
        chk("spur_line_kept", cache_read_data_o, exp_line(32'hC0));
        start_fill(32'h0000_0300, 32'h3000);
        wait_valid("spur_fill", 20);
        check_addrs("spur_fill", 32'h0000_0300);
        chk("spur_fill_line", line_cap, exp_line(32'h3000));
        chk("spur_err_sticky", 128'(err_o), 128'd1);
        step(); step();

        // Two misses back to back: the second is taken in the IDLE cycle after the pulse.
        start_fill(32'h0000_0100, 32'hD0);
        wait_valid("miss1", 20);
        chk("miss1_line", line_cap, exp_line(32'hD0));
        c0 = valid_cyc;
        start_fill(32'h0000_0200, 32'hF0);
        c0 = cyc;
        wait_valid("miss2", 20);
        chk("miss2_first_req", 128'(first_req_cyc), 128'(c0 + 2));
        check_addrs("miss2", 32'h0000_0200);
        chk("miss2_line", line_cap, exp_line(32'hF0));
        step(); step();
        chk("miss2_one_pulse", 128'(n_valid), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
